// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer, the memory address register and the
// execute side of the control unit.
//
// Handshakes:
//   - mar_load is a one-cycle strobe with no back-pressure: the MAR captures
//     memory[address] at the end of that cycle and presents it on
//     instruction one cycle later.
//   - ir_valid/exec_done form a valid/done pair. ir_valid rises with a fresh
//     ir and stays high, with ir, pc and address frozen, until exec_done is
//     sampled high in the same cycle. jump_en, jump_addr and halt only count
//     in that cycle. exec_done while ir_valid is low is ignored.
//   - start is only looked at while the sequencer is idle.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] address;
    logic              mar_load;
    logic [DATA_W-1:0] instruction;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic              exec_done;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              halt;
    logic              halted;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        fsm_state;

    // Sequencer side.
    modport master (
        input  start,
        input  instruction,
        input  exec_done,
        input  jump_en,
        input  jump_addr,
        input  halt,
        output address,
        output mar_load,
        output ir,
        output ir_valid,
        output halted,
        output pc,
        output fsm_state
    );

    // MAR / execute / debug side.
    modport slave (
        output start,
        output instruction,
        output exec_done,
        output jump_en,
        output jump_addr,
        output halt,
        input  address,
        input  mar_load,
        input  ir,
        input  ir_valid,
        input  halted,
        input  pc,
        input  fsm_state
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the program counter, strobes the MAR, loads the
// instruction register one cycle later and holds it until the execute side
// reports completion, then applies halt/jump and starts the next fetch.
// All outputs except mar_load come straight from registers; mar_load is a
// pure decode of the state register.
module fetch_sequencer #(
    parameter int                ADDR_W       = 8,
    parameter int                DATA_W       = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input logic               clk,
    input logic               rst,
    fetch_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]        state_q,    state_d;
    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] ir_q,       ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              halted_q,   halted_d;

    // Next-state and datapath update; every register holds by default.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                end
            end

            // The strobe is decoded from this state; address already
            // equals pc here because it is only ever loaded alongside pc.
            S_FETCH: begin
                state_d = S_WAIT;
            end

            // MAR output is valid now: latch it and advance pc. address is
            // deliberately left on the fetched location until completion.
            S_WAIT: begin
                ir_d       = bus.instruction;
                ir_valid_d = 1'b1;
                pc_d       = pc_q + ADDR_W'(1);
                state_d    = S_EXEC;
            end

            // Halt outranks jump; a plain completion refetches at the
            // already-incremented pc.
            S_EXEC: begin
                if (bus.exec_done) begin
                    ir_valid_d = 1'b0;
                    if (bus.halt) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else if (bus.jump_en) begin
                        pc_d    = bus.jump_addr;
                        addr_d  = bus.jump_addr;
                        state_d = S_FETCH;
                    end else begin
                        addr_d  = pc_q;
                        state_d = S_FETCH;
                    end
                end
            end

            // Sticky until reset.
            S_HALT: begin
                state_d = S_HALT;
            end

            // Unused encodings fall back to idle.
            default: begin
                state_d    = S_IDLE;
                ir_valid_d = 1'b0;
                halted_d   = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_VECTOR;
            addr_q     <= RESET_VECTOR;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.mar_load  = (state_q == S_FETCH);
    assign bus.address   = addr_q;
    assign bus.pc        = pc_q;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.halted    = halted_q;
    assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a memory behind a MAR model, a driver playing
// the execute side, and a monitor comparing fetches and instruction-register
// loads against queues filled by a program-level reference model.
module tb_fetch_sequencer;

    localparam int              AW = 8;
    localparam int              DW = 8;
    localparam logic [AW-1:0]   RV = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    fetch_sequencer #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .RESET_VECTOR(RV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock.
    always #5 clk = ~clk;

    // Memory behind a registered MAR.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (bus.mar_load) bus.instruction <= mem[bus.address];
    end

    // Scoreboard state.
    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_ir_q[$];
    logic [AW-1:0] exp_pc_q[$];
    logic [AW-1:0] model_fetch;
    bit            exp_halted   = 1'b0;
    bit            expect_fetch = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT fetches or loads ir.
    logic [DW-1:0] cur_ir;
    logic [AW-1:0] cur_pc;
    logic [AW-1:0] cur_addr;
    int            cycle = 0;
    int            last_fetch_cycle = 0;
    bit            iv_prev = 1'b0;

    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            iv_prev = 1'b0;
        end else begin
            if (expect_fetch) begin
                check("fetch_after_exec_done", 32'(bus.mar_load), 32'd1);
                expect_fetch = 1'b0;
            end
            if (bus.mar_load) begin
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_mar_load: got address %0h expected no fetch", bus.address);
                end else begin
                    cur_addr = exp_addr_q.pop_front();
                    check("fetch_address", 32'(bus.address), 32'(cur_addr));
                    check("pc_at_fetch", 32'(bus.pc), 32'(cur_addr));
                    last_fetch_cycle = cycle;
                end
            end
            if (bus.ir_valid && !iv_prev) begin
                checks++;
                if (exp_ir_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ir_valid: got ir %0h expected no load", bus.ir);
                end else begin
                    cur_ir = exp_ir_q.pop_front();
                    cur_pc = exp_pc_q.pop_front();
                    check("ir_loaded", 32'(bus.ir), 32'(cur_ir));
                    check("pc_after_wait", 32'(bus.pc), 32'(cur_pc));
                    check("fetch_to_valid_latency", 32'(cycle - last_fetch_cycle), 32'd2);
                end
            end else if (bus.ir_valid) begin
                check("ir_held", 32'(bus.ir), 32'(cur_ir));
                check("pc_held", 32'(bus.pc), 32'(cur_pc));
                check("address_held", 32'(bus.address), 32'(cur_addr));
            end
            check("halted", 32'(bus.halted), 32'(exp_halted));
            iv_prev = bus.ir_valid;
        end
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a fetch of address a yields mem[a] and leaves pc at a+1.
    task automatic push_fetch(input logic [AW-1:0] a);
        logic [AW-1:0] nxt;
        nxt = a + 8'd1;
        exp_addr_q.push_back(a);
        exp_ir_q.push_back(mem[a]);
        exp_pc_q.push_back(nxt);
        model_fetch = a;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.exec_done = 1'b0;
        bus.jump_en   = 1'b0;
        bus.halt      = 1'b0;
        bus.jump_addr = '0;
    endtask

    task automatic noise();
        bus.start     = 1'($urandom_range(0, 1));
        bus.exec_done = 1'($urandom_range(0, 1));
        bus.jump_en   = 1'($urandom_range(0, 1));
        bus.halt      = 1'($urandom_range(0, 1));
        bus.jump_addr = 8'($urandom_range(0, 255));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        exp_addr_q.delete();
        exp_ir_q.delete();
        exp_pc_q.delete();
        expect_fetch = 1'b0;
        tick();
        rst = 1'b0;
        exp_halted = 1'b0;
        check("rst_pc", 32'(bus.pc), 32'(RV));
        check("rst_address", 32'(bus.address), 32'(RV));
        check("rst_ir", 32'(bus.ir), 32'd0);
        check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_mar_load", 32'(bus.mar_load), 32'd0);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        push_fetch(RV);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_exec(output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (bus.ir_valid !== 1'b1) begin
            if (n == 20) begin
                checks++;
                errors++;
                $display("FAIL exec_timeout: ir_valid got %b after %0d cycles expected 1", bus.ir_valid, n);
                ok = 1'b0;
                idle_inputs();
                return;
            end
            noise();
            tick();
            n++;
        end
        idle_inputs();
    endtask

    // Plays one instruction: stall `delay` cycles, then complete it.
    task automatic exec_instr(input int delay, input bit jmp, input logic [AW-1:0] jaddr, input bit hlt);
        bit ok;
        logic [AW-1:0] nxt;
        wait_exec(ok);
        if (!ok) return;
        repeat (delay) begin
            bus.jump_en   = 1'($urandom_range(0, 1));
            bus.halt      = 1'($urandom_range(0, 1));
            bus.jump_addr = 8'($urandom_range(0, 255));
            tick();
        end
        bus.exec_done = 1'b1;
        bus.jump_en   = jmp;
        bus.jump_addr = jaddr;
        bus.halt      = hlt;
        if (!hlt) begin
            nxt = jmp ? jaddr : 8'(model_fetch + 8'd1);
            push_fetch(nxt);
        end
        tick();
        idle_inputs();
        if (hlt) exp_halted = 1'b1;
        else     expect_fetch = 1'b1;
    endtask

    // After a halt: random input activity must not restart anything.
    task automatic halt_noise(input int n);
        repeat (n) begin
            noise();
            tick();
        end
        idle_inputs();
        check("halted_queue_drained", 32'(exp_addr_q.size() + exp_ir_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));

        // Reset then single fetch of A5.
        mem[0] = 8'hA5;
        do_reset();
        do_start();
        exec_instr(0, 1'b0, 8'h00, 1'b1);
        halt_noise(3);

        // Sequential run at full rate.
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++) exec_instr(0, 1'b0, 8'h00, 1'b0);
        exec_instr(0, 1'b0, 8'h00, 1'b1);
        halt_noise(2);

        // Wrap-around through 8'hFF.
        mem[255] = 8'h7E;
        do_reset();
        do_start();
        exec_instr(0, 1'b1, 8'hFF, 1'b0);
        exec_instr(1, 1'b0, 8'h00, 1'b0);
        exec_instr(0, 1'b0, 8'h00, 1'b1);
        halt_noise(2);

        // Halt beats jump; then reset while halted.
        do_reset();
        do_start();
        exec_instr(0, 1'b1, 8'h40, 1'b1);
        halt_noise(6);
        do_reset();

        // Jump without halt, a 5-cycle stall, and a self-jump refetch.
        do_start();
        exec_instr(0, 1'b1, 8'h40, 1'b0);
        exec_instr(5, 1'b0, 8'h00, 1'b0);
        exec_instr(0, 1'b1, model_fetch, 1'b0);
        exec_instr(2, 1'b0, 8'h00, 1'b1);
        halt_noise(2);

        // Reset during WAIT, then a clean restart from the reset vector.
        do_reset();
        do_start();
        tick();
        do_reset();
        do_start();
        exec_instr(0, 1'b0, 8'h00, 1'b1);
        halt_noise(2);

        // Randomised program.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        do_reset();
        do_start();
        for (int i = 0; i < 60; i++) begin
            int            d;
            bit            j;
            logic [AW-1:0] ja;
            d  = $urandom_range(0, 3);
            j  = ($urandom_range(0, 3) == 0);
            ja = ($urandom_range(0, 4) == 0) ? model_fetch : 8'($urandom_range(0, 255));
            exec_instr(d, j, ja, 1'b0);
        end
        exec_instr(0, 1'b0, 8'h00, 1'b1);
        halt_noise(4);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Upstream stage of the memory address register. It owns the program counter and presents `address` with a one-cycle `mar_load` strobe. One cycle later it captures the MAR's registered `instruction` output into an instruction register for the control unit. It then holds that instruction until the execute side reports completion, applies any jump or halt, and starts the next fetch.

Parameters:
- ADDR_W, 8, width of program counter and address bus.
- DATA_W, 8, width of instruction word.
- RESET_VECTOR, 8'h00, program counter value after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  leaves IDLE and begins fetching at the current PC.
- address  output  ADDR_W  address to MAR; registered copy of PC.
- mar_load  output  1  one-cycle strobe; MAR captures memory[address] at the end of this cycle.
- instruction  input  DATA_W  registered instruction from MAR; valid the cycle after mar_load.
- ir  output  DATA_W  instruction register contents.
- ir_valid  output  1  ir holds a fresh instruction awaiting execution.
- exec_done  input  1  execute side has finished with ir; sampled only in EXEC.
- jump_en  input  1  with exec_done, next PC = jump_addr.
- jump_addr  input  ADDR_W  jump target.
- halt  input  1  with exec_done, stop fetching.
- halted  output  1  sequencer is in HALT.
- pc  output  ADDR_W  current program counter, for debug and the control unit.

Behaviour:
- Reset (rst=1 at a rising edge):
  - pc = RESET_VECTOR; address = RESET_VECTOR; ir = 0.
  - mar_load = 0; ir_valid = 0; halted = 0; state = IDLE.
  - Reset wins over every other input in any state, including mid-fetch and HALT.
  - Any in-flight fetch is discarded.
- States: IDLE, FETCH, WAIT, EXEC, HALT.
- IDLE: all strobes low. start=1 → FETCH. Otherwise stay.
- FETCH:
  - mar_load = 1 (decoded from state, asserted exactly this one cycle); address = pc.
  - Next state WAIT unconditionally.
- WAIT:
  - mar_load = 0; `instruction` now holds memory[pc].
  - At the end of the cycle: ir <= instruction; ir_valid <= 1; pc <= pc + 1 modulo 2^ADDR_W (255 wraps to 0); → EXEC.
- EXEC: ir_valid = 1; ir, pc and address are stable. On exec_done=1:
  - halt=1 → HALT; ir_valid <= 0; halted <= 1; pc unchanged. Halt has priority over jump.
  - else jump_en=1 → pc <= jump_addr; address <= jump_addr; ir_valid <= 0; → FETCH.
  - else address <= pc (already incremented); ir_valid <= 0; → FETCH.
  - exec_done=0 → stay; all outputs held.
- HALT: halted = 1; mar_load = 0; ignores start, exec_done, jump_en and halt. Left only by rst.
- address always equals pc whenever mar_load = 1.
- Latency:
  - Fetch → ir_valid: FETCH entry to ir_valid high = 2 cycles.
  - Minimum instruction period: 3 cycles (exec_done high on the first EXEC cycle).
- Inputs outside their sampling state (exec_done/jump_en/halt outside EXEC, start outside IDLE) have no effect.
- jump_addr equal to the current pc is legal: that instruction is refetched.
- No combinational path from any input to any output except mar_load, which depends on state only.

Test Plan:
- Reset then start: after rst, pc=0, ir_valid=0, halted=0. Memory[0]=8'hA5 behind a MAR model, pulse start → mar_load high exactly 1 cycle with address=0; 2 cycles after FETCH entry ir=8'hA5, ir_valid=1, pc=1.
- Sequential run: exec_done tied high, memory[0..3]=11,22,33,44 → ir sequence 11,22,33,44 at a 3-cycle period; pc 1,2,3,4.
- Wrap-around: set pc to 8'hFF via jump, fetch memory[255]=8'h7E → ir=8'h7E; pc=8'h00 after WAIT; next mar_load has address=0.
- Jump vs halt priority: in EXEC, drive exec_done=1, jump_en=1, jump_addr=8'h40, halt=1 → HALT, halted=1, no further mar_load. Repeat with halt=0 → next FETCH has address=8'h40.
- Stall: hold exec_done=0 for 5 cycles in EXEC → ir, pc, ir_valid stable, no mar_load. Raise exec_done → FETCH next cycle.
- Reset mid-operation: assert rst during WAIT and during HALT → next cycle state IDLE, pc=0, ir=0, ir_valid=0, halted=0. A later start refetches address 0.
